// File: rtl/mem_map_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_map_pkg
// Description : Shared memory-map constants, region decode type and the
//               screen-queue entry type used by mem_responder and scr_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_map_pkg;

  localparam logic [14:0] RAM_BASE = 15'h0000;
  localparam logic [14:0] SCR_BASE = 15'h4000;
  localparam logic [14:0] SCR_LAST = 15'h5FFF;
  localparam logic [14:0] KBD_ADDR = 15'h6000;

  typedef enum logic [1:0] {
    REG_RAM      = 2'd0,
    REG_SCR      = 2'd1,
    REG_KBD      = 2'd2,
    REG_UNMAPPED = 2'd3
  } region_e;

  typedef struct packed {
    logic [12:0] addr;
    logic [15:0] data;
  } scr_entry_t;

  // Map a CPU data address onto the region it selects.
  function automatic region_e decode_region(input logic [14:0] addr);
    region_e r;
    if (addr < SCR_BASE)        r = REG_RAM;
    else if (addr <= SCR_LAST)  r = REG_SCR;
    else if (addr == KBD_ADDR)  r = REG_KBD;
    else                        r = REG_UNMAPPED;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_responder_scr_fifo.sv
`default_nettype none
// ============================================================================
// Module      : scr_fifo
// Description : Screen write queue. Registered head, no fall-through; a push
//               into a full queue is accepted only when the head pops in the
//               same cycle, otherwise it is dropped and push_drop pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module scr_fifo
  import mem_map_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  scr_entry_t push_entry,
  output logic       push_drop,
  input  logic       pop_ready,
  output logic       head_valid,
  output scr_entry_t head_entry
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  scr_entry_t       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty, full, do_pop, do_push;

  // Handshake decode and next-state pointers; pointers wrap naturally because
  // the depth is a power of two.
  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == DEPTH_C);
    do_pop    = !empty && pop_ready;
    do_push   = push && (!full || do_pop);
    push_drop = push && full && !do_pop;
    wr_ptr_d  = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d   = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Queue control state; reset empties the queue immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry;
  end

  // Head is forced to zero when empty so the display side sees clean zeros.
  always_comb begin
    head_valid = !empty;
    head_entry = empty ? '0 : mem_q[rd_ptr_q];
  end

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : CPU data-memory responder: address decode, backing RAM,
//               keyboard register, screen write queue and sticky flags.
//               Optional build macro MEM_RESP_UNMAPPED_ERR_EN enables the
//               sticky bus_err flag on writes to unmapped addresses; without
//               it bus_err is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder
  import mem_map_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int RAM_WORDS  = 24576
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [14:0] addressM,
  input  logic [15:0] outM,
  input  logic        writeM,
  output logic [15:0] inM,
  input  logic [15:0] kbd_code,
  input  logic        kbd_valid,
  output logic [12:0] scr_addr,
  output logic [15:0] scr_data,
  output logic        scr_valid,
  input  logic        scr_ready,
  output logic        scr_overflow,
  output logic        bus_err
);

  region_e     region;
  logic        wr_mem, scr_push, scr_drop;
  scr_entry_t  push_entry, head_entry;
  logic [15:0] ram_q [RAM_WORDS];
  logic [15:0] kbd_reg_q, kbd_reg_d;
  logic        scr_overflow_q, scr_overflow_d;

  // Region decode, write qualification and zero-latency read mux.
  always_comb begin
    region     = decode_region(addressM);
    wr_mem     = writeM && ((region == REG_RAM) || (region == REG_SCR));
    scr_push   = writeM && (region == REG_SCR);
    push_entry = '{addr: addressM[12:0], data: outM};
    case (region)
      REG_RAM, REG_SCR: inM = ram_q[addressM];
      REG_KBD:          inM = kbd_reg_q;
      default:          inM = 16'h0000;
    endcase
  end

  // Backing RAM; read-before-write falls out of the combinational read path.
  always_ff @(posedge clk) begin
    if (wr_mem) ram_q[addressM] <= outM;
  end

  // Keyboard register next state: a new code outranks the CPU acknowledge.
  always_comb begin
    kbd_reg_d = kbd_reg_q;
    if (kbd_valid)
      kbd_reg_d = kbd_code;
    else if (writeM && (region == REG_KBD))
      kbd_reg_d = 16'h0000;
    scr_overflow_d = scr_overflow_q | scr_drop;
  end

  // Keyboard register and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kbd_reg_q      <= 16'h0000;
      scr_overflow_q <= 1'b0;
    end else begin
      kbd_reg_q      <= kbd_reg_d;
      scr_overflow_q <= scr_overflow_d;
    end
  end

  scr_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_scr_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (scr_push),
    .push_entry (push_entry),
    .push_drop  (scr_drop),
    .pop_ready  (scr_ready),
    .head_valid (scr_valid),
    .head_entry (head_entry)
  );

  assign scr_addr     = head_entry.addr;
  assign scr_data     = head_entry.data;
  assign scr_overflow = scr_overflow_q;

`ifdef MEM_RESP_UNMAPPED_ERR_EN
  logic bus_err_q, bus_err_d;

  // Sticky error on any write that lands outside the memory map.
  always_comb begin
    bus_err_d = bus_err_q | (writeM && (region == REG_UNMAPPED));
  end

  // Bus error flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus_err_q <= 1'b0;
    else        bus_err_q <= bus_err_d;
  end

  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_responder
// Description : Directed self-checking bench for mem_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [14:0] addressM = '0;
  logic [15:0] outM = '0;
  logic        writeM = 1'b0;
  logic [15:0] inM;
  logic [15:0] kbd_code = '0;
  logic        kbd_valid = 1'b0;
  logic [12:0] scr_addr;
  logic [15:0] scr_data;
  logic        scr_valid;
  logic        scr_ready = 1'b0;
  logic        scr_overflow;
  logic        bus_err;

  int total = 0;
  int bad   = 0;

  mem_responder #(.FIFO_DEPTH(4), .RAM_WORDS(24576)) dut (
    .clk(clk), .rst_n(rst_n), .addressM(addressM), .outM(outM),
    .writeM(writeM), .inM(inM), .kbd_code(kbd_code), .kbd_valid(kbd_valid),
    .scr_addr(scr_addr), .scr_data(scr_data), .scr_valid(scr_valid),
    .scr_ready(scr_ready), .scr_overflow(scr_overflow), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cpu_write(input logic [14:0] a, input logic [15:0] d);
    addressM = a; outM = d; writeM = 1'b1;
    tick();
    writeM = 1'b0;
  endtask

  // Pulse reset between clock edges and release it between edges.
  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #10 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    addressM = 15'h6000; #1;
    total++; if (scr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b exp 0", scr_valid); end
    total++; if ({scr_addr, scr_data} !== 29'h0) begin bad++; $display("FAIL rst_head: got %h exp 0", {scr_addr, scr_data}); end
    total++; if ({scr_overflow, bus_err} !== 2'b00) begin bad++; $display("FAIL rst_flags: got %b exp 00", {scr_overflow, bus_err}); end
    total++; if (inM !== 16'h0000) begin bad++; $display("FAIL rst_kbd: got %h exp 0000", inM); end
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ram();
    cpu_write(15'h0010, 16'h1111);
    addressM = 15'h0010; outM = 16'h1234; writeM = 1'b1; #1;
    total++; if (inM !== 16'h1111) begin bad++; $display("FAIL ram_rbw: got %h exp 1111", inM); end
    tick(); writeM = 1'b0; #1;
    total++; if (inM !== 16'h1234) begin bad++; $display("FAIL ram_read: got %h exp 1234", inM); end
  endtask

  task automatic test_screen_handshake();
    scr_ready = 1'b0;
    addressM = 15'h4001; outM = 16'hAAAA; writeM = 1'b1; #1;
    total++; if (scr_valid !== 1'b0) begin bad++; $display("FAIL scr_no_fallthrough: got %b exp 0", scr_valid); end
    tick(); writeM = 1'b0;
    total++; if (scr_valid !== 1'b1) begin bad++; $display("FAIL scr_latency: got %b exp 1", scr_valid); end
    cpu_write(15'h4002, 16'h5555);
    tick();
    total++; if ({scr_valid, scr_addr, scr_data} !== {1'b1, 13'h0001, 16'hAAAA}) begin bad++; $display("FAIL scr_head_held: got %h exp 1_0001_aaaa", {scr_valid, scr_addr, scr_data}); end
    addressM = 15'h4001; #1;
    total++; if (inM !== 16'hAAAA) begin bad++; $display("FAIL scr_ram: got %h exp aaaa", inM); end
    scr_ready = 1'b1;
    tick();
    total++; if ({scr_valid, scr_addr, scr_data} !== {1'b1, 13'h0002, 16'h5555}) begin bad++; $display("FAIL scr_pop1: got %h exp 1_0002_5555", {scr_valid, scr_addr, scr_data}); end
    tick();
    total++; if (scr_valid !== 1'b0) begin bad++; $display("FAIL scr_pop2: got %b exp 0", scr_valid); end
    scr_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [15:0] vals [5];
    vals[0] = 16'h0101; vals[1] = 16'h0202; vals[2] = 16'h0303; vals[3] = 16'h0404; vals[4] = 16'hBEEF;
    // Full queue, no pop: fifth push dropped.
    scr_ready = 1'b0;
    for (int i = 0; i < 5; i++) cpu_write(15'h4010 + 15'(i), vals[i]);
    total++; if (scr_overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b exp 1", scr_overflow); end
    addressM = 15'h4014; #1;
    total++; if (inM !== 16'hBEEF) begin bad++; $display("FAIL ovf_ram: got %h exp beef", inM); end
    scr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if ({scr_valid, scr_addr, scr_data} !== {1'b1, 13'h0010 + 13'(i), vals[i]}) begin bad++; $display("FAIL ovf_drain%0d: got %h exp %h", i, {scr_valid, scr_addr, scr_data}, {1'b1, 13'h0010 + 13'(i), vals[i]}); end
      tick();
    end
    total++; if (scr_valid !== 1'b0) begin bad++; $display("FAIL ovf_dropped: got %b exp 0", scr_valid); end
    scr_ready = 1'b0;
    // Full queue with a pop in the same cycle: push accepted.
    pulse_reset();
    for (int i = 0; i < 4; i++) cpu_write(15'h4010 + 15'(i), vals[i]);
    scr_ready = 1'b1;
    cpu_write(15'h4014, vals[4]);
    scr_ready = 1'b0; #1;
    total++; if (scr_overflow !== 1'b0) begin bad++; $display("FAIL full_pop_flag: got %b exp 0", scr_overflow); end
    scr_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      total++; if ({scr_valid, scr_addr, scr_data} !== {1'b1, 13'h0010 + 13'(i), vals[i]}) begin bad++; $display("FAIL full_pop_drain%0d: got %h exp %h", i, {scr_valid, scr_addr, scr_data}, {1'b1, 13'h0010 + 13'(i), vals[i]}); end
      tick();
    end
    total++; if (scr_valid !== 1'b0) begin bad++; $display("FAIL full_pop_empty: got %b exp 0", scr_valid); end
    scr_ready = 1'b0;
  endtask

  task automatic test_keyboard();
    kbd_code = 16'h0041; kbd_valid = 1'b1;
    tick(); kbd_valid = 1'b0;
    addressM = 15'h6000; #1;
    total++; if (inM !== 16'h0041) begin bad++; $display("FAIL kbd_load: got %h exp 0041", inM); end
    cpu_write(15'h6000, 16'h9999); #1;
    total++; if (inM !== 16'h0000) begin bad++; $display("FAIL kbd_ack: got %h exp 0000", inM); end
    kbd_code = 16'h0042; kbd_valid = 1'b1;
    cpu_write(15'h6000, 16'h9999);
    kbd_valid = 1'b0; #1;
    total++; if (inM !== 16'h0042) begin bad++; $display("FAIL kbd_priority: got %h exp 0042", inM); end
  endtask

  task automatic test_unmapped();
    #1;
    total++; if (bus_err !== 1'b0) begin bad++; $display("FAIL unm_pre: got %b exp 0", bus_err); end
    cpu_write(15'h7000, 16'hDEAD);
    addressM = 15'h7000; #1;
    total++; if (inM !== 16'h0000) begin bad++; $display("FAIL unm_read: got %h exp 0000", inM); end
    addressM = 15'h0010; #1;
    total++; if (inM !== 16'h1234) begin bad++; $display("FAIL unm_ram: got %h exp 1234", inM); end
    total++; if (scr_valid !== 1'b0) begin bad++; $display("FAIL unm_queue: got %b exp 0", scr_valid); end
`ifdef MEM_RESP_UNMAPPED_ERR_EN
    total++; if (bus_err !== 1'b1) begin bad++; $display("FAIL unm_bus_err: got %b exp 1", bus_err); end
`else
    total++; if (bus_err !== 1'b0) begin bad++; $display("FAIL unm_bus_err: got %b exp 0", bus_err); end
`endif
  endtask

  task automatic test_reset_mid_queue();
    scr_ready = 1'b0;
    for (int i = 0; i < 3; i++) cpu_write(15'h4100 + 15'(i), 16'hC000 + 16'(i));
    total++; if (scr_valid !== 1'b1) begin bad++; $display("FAIL mid_valid: got %b exp 1", scr_valid); end
    scr_ready = 1'b1;
    #2 rst_n = 1'b0; #1;
    total++; if ({scr_valid, scr_addr, scr_data, scr_overflow, bus_err} !== 32'h0) begin bad++; $display("FAIL mid_rst_out: got %h exp 0", {scr_valid, scr_addr, scr_data, scr_overflow, bus_err}); end
    scr_ready = 1'b0;
    #10 rst_n = 1'b1;
    tick(); tick();
    total++; if (scr_valid !== 1'b0) begin bad++; $display("FAIL mid_after: got %b exp 0", scr_valid); end
    addressM = 15'h0010; #1;
    total++; if (inM !== 16'h1234) begin bad++; $display("FAIL mid_ram_kept: got %h exp 1234", inM); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_screen_handshake();
    test_overflow();
    test_keyboard();
    test_unmapped();
    test_reset_mid_queue();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
